// File: rtl/player_input_ctrl.sv
// Turns two bouncy, asynchronous buttons into one move request per press. Requests are issued on a periodic update_player strobe.
// Latency: from a raw key edge to a pending request, 2+DEBOUNCE edges; outputs change on the next tick wrap. There is no backpressure.
// At most one of left/right is raised, and only while update_player is high.
module player_input_ctrl #(
    parameter int TICK_DIV = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic game_Over,
    input  logic key_left,
    input  logic key_right,
    output logic update_player,
    output logic left,
    output logic right
);

    localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    // Bit 0 is the left key and bit 1 is the right key.
    logic [1:0]        sync1_q, sync1_d;
    logic [1:0]        sync2_q, sync2_d;
    logic [1:0]        level_q, level_d;
    logic [DB_W-1:0]   cnt_q [2];
    logic [DB_W-1:0]   cnt_d [2];
    logic [1:0]        rise;

    logic [TICK_W-1:0] tick_q, tick_d;
    logic              wrap;

    logic              pend_left_q, pend_left_d;
    logic              pend_right_q, pend_right_d;
    logic              update_player_q, update_player_d;
    logic              left_q, left_d;
    logic              right_q, right_d;

    // Synchronizers and debouncers. A level is accepted only after it has stayed stable for DEBOUNCE samples.
    always_comb begin
        sync1_d = {key_right, key_left};
        sync2_d = sync1_q;
        level_d = level_q;
        for (int k = 0; k < 2; k++) begin
            cnt_d[k] = '0;
            if (sync2_q[k] != level_q[k]) begin
                if (cnt_q[k] == DB_LAST) begin
                    level_d[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
        rise = level_d & ~level_q;
    end

    always_comb begin
        wrap   = (tick_q == TICK_LAST);
        tick_d = wrap ? '0 : tick_q + 1'b1;
    end

    // A new edge on the wrap cycle takes priority over the clear, so that edge is served by the next tick.
    always_comb begin
        pend_left_d  = wrap ? 1'b0 : pend_left_q;
        pend_right_d = wrap ? 1'b0 : pend_right_q;
        if (game_Over) begin
            pend_left_d  = 1'b0;
            pend_right_d = 1'b0;
        end else if (rise[0] && rise[1]) begin
            pend_left_d  = 1'b0;
            pend_right_d = 1'b0;
        end else if (rise[0]) begin
            pend_left_d  = 1'b1;
            pend_right_d = 1'b0;
        end else if (rise[1]) begin
            pend_left_d  = 1'b0;
            pend_right_d = 1'b1;
        end
    end

    always_comb begin
        update_player_d = wrap;
        left_d          = wrap & pend_left_q  & ~game_Over;
        right_d         = wrap & pend_right_q & ~game_Over;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q         <= '0;
            sync2_q         <= '0;
            level_q         <= '0;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= '0;
            end
            tick_q          <= '0;
            pend_left_q     <= 1'b0;
            pend_right_q    <= 1'b0;
            update_player_q <= 1'b0;
            left_q          <= 1'b0;
            right_q         <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            level_q         <= level_d;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            tick_q          <= tick_d;
            pend_left_q     <= pend_left_d;
            pend_right_q    <= pend_right_d;
            update_player_q <= update_player_d;
            left_q          <= left_d;
            right_q         <= right_d;
        end
    end

    assign update_player = update_player_q;
    assign left          = left_q;
    assign right         = right_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed scoreboard bench for player_input_ctrl: the stimulus side queues the strobes it expects, and the monitor matches each strobe the DUT produces.
module tb_player_input_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic game_Over = 1'b0;
    logic key_left = 1'b0;
    logic key_right = 1'b0;
    logic update_player, left, right;

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;

    typedef struct {
        int   c;
        logic l;
        logic r;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    player_input_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .game_Over     (game_Over),
        .key_left      (key_left),
        .key_right     (key_right),
        .update_player (update_player),
        .left          (left),
        .right         (right)
    );

    always #5 clk = ~clk;

    // Count rising edges since the last reset. Edge 1 is the first edge with reset low.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (update_player) begin
            nvec++;
            if (sb.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_strobe cyc=%0d got left=%0b right=%0b, no strobe required", cyc, left, right);
            end else begin
                e = sb.pop_front();
                if (cyc != e.c || left !== e.l || right !== e.r) begin
                    nfail++;
                    $display("FAIL strobe got cyc=%0d left=%0b right=%0b, required cyc=%0d left=%0b right=%0b",
                             cyc, left, right, e.c, e.l, e.r);
                end
            end
        end else begin
            nvec++;
            if (left !== 1'b0 || right !== 1'b0) begin
                nfail++;
                $display("FAIL idle_outputs cyc=%0d got left=%0b right=%0b, required 0 0", cyc, left, right);
            end
        end
    end

    task automatic expect_strobe(input int c, input logic l, input logic r);
        exp_t x;
        x.c = c;
        x.l = l;
        x.r = r;
        sb.push_back(x);
    endtask

    task automatic check_drained(input string name);
        nvec++;
        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL %s_missing got %0d strobes outstanding, required 0 (next expected cyc=%0d)",
                     name, sb.size(), sb[0].c);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        key_left  = 1'b0;
        key_right = 1'b0;
        game_Over = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if (update_player !== 1'b0 || left !== 1'b0 || right !== 1'b0) begin
            nfail++;
            $display("FAIL reset_state got upd=%0b left=%0b right=%0b, required 0 0 0", update_player, left, right);
        end
        reset = 1'b0;
    endtask

    // Wait until edge n has occurred, then sample 1 time unit after that edge.
    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 1000) begin
                nvec++;
                nfail++;
                $display("FAIL wait_cyc timeout got cyc=%0d, required %0d", cyc, n);
                break;
            end
        end
    endtask

    initial begin
        #1;
        // Idle: strobes at edges 8, 16 and 24 only.
        do_reset();
        expect_strobe(8, 1'b0, 1'b0);
        expect_strobe(16, 1'b0, 1'b0);
        expect_strobe(24, 1'b0, 1'b0);
        wait_cyc(28);
        check_drained("idle");

        // Held left key: debounced at edge 7, reported once at edge 8.
        do_reset();
        expect_strobe(8, 1'b1, 1'b0);
        expect_strobe(16, 1'b0, 1'b0);
        expect_strobe(24, 1'b0, 1'b0);
        wait_cyc(1);
        key_left = 1'b1;
        wait_cyc(28);
        check_drained("held_left");

        // Right-key bounce: the glitch is rejected, and an edge accepted on the wrap at edge 16 is reported at edge 24.
        do_reset();
        expect_strobe(8, 1'b0, 1'b0);
        expect_strobe(16, 1'b0, 1'b0);
        expect_strobe(24, 1'b0, 1'b1);
        expect_strobe(32, 1'b0, 1'b0);
        wait_cyc(1);
        key_right = 1'b1;
        wait_cyc(3);
        key_right = 1'b0;
        wait_cyc(10);
        key_right = 1'b1;
        wait_cyc(34);
        check_drained("bounce");

        // Left at edge 9, then right at edge 12: the newest edge wins.
        do_reset();
        expect_strobe(8, 1'b0, 1'b0);
        expect_strobe(16, 1'b0, 1'b1);
        expect_strobe(24, 1'b0, 1'b0);
        wait_cyc(3);
        key_left = 1'b1;
        wait_cyc(6);
        key_right = 1'b1;
        wait_cyc(26);
        check_drained("newest_wins");

        // Both keys debounced on the same edge, which cancels both requests.
        do_reset();
        expect_strobe(8, 1'b0, 1'b0);
        expect_strobe(16, 1'b0, 1'b0);
        wait_cyc(3);
        key_left  = 1'b1;
        key_right = 1'b1;
        wait_cyc(18);
        check_drained("simultaneous");

        // Game over suppresses requests; after it ends, a fresh press is reported.
        do_reset();
        game_Over = 1'b1;
        expect_strobe(8, 1'b0, 1'b0);
        expect_strobe(16, 1'b0, 1'b0);
        expect_strobe(24, 1'b0, 1'b0);
        expect_strobe(32, 1'b0, 1'b0);
        expect_strobe(40, 1'b1, 1'b0);
        wait_cyc(1);
        key_left = 1'b1;
        wait_cyc(18);
        game_Over = 1'b0;
        key_left  = 1'b0;
        wait_cyc(27);
        key_left = 1'b1;
        wait_cyc(42);
        check_drained("game_over");

        // The request is pending at edge 7; a reset discards it.
        do_reset();
        wait_cyc(1);
        key_left = 1'b1;
        wait_cyc(7);
        check_drained("pre_reset");
        do_reset();
        expect_strobe(8, 1'b0, 1'b0);
        expect_strobe(16, 1'b0, 1'b0);
        wait_cyc(18);
        check_drained("mid_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

endmodule
